// File: rtl/gbvga_pkg.sv
// gbvga_pkg: shared Game Boy framebuffer geometry, 800x600 scanout timing,
// arbiter state encoding and the read-pipeline slot bundle.
package gbvga_pkg;

  localparam int GB_W          = 160;
  localparam int GB_H          = 144;
  localparam int PIX_PER_WORD  = 4;
  localparam int WORDS_PER_ROW = GB_W / PIX_PER_WORD;
  localparam int FB_DEPTH      = GB_H * WORDS_PER_ROW;
  localparam int FB_AW         = 13;

  localparam int H_VIS        = 800;
  localparam int H_FP         = 40;
  localparam int H_SYNC       = 128;
  localparam int H_BP         = 88;
  localparam int H_TOTAL      = 1056;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VIS        = 600;
  localparam int V_FP         = 1;
  localparam int V_SYNC       = 4;
  localparam int V_BP         = 23;
  localparam int V_TOTAL      = 628;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DRAIN
  } arb_state_e;

  typedef struct packed {
    logic       v;
    logic [5:0] idx;
  } rd_slot_t;

endpackage

// File: rtl/fb_read_seq.sv
// fb_read_seq: row base, word counter and 2-deep read pipeline.
// In: clk, reset_n, start, row, issue, ram_rdata. Out: rd_addr, last, lb_*, fetch_done.
module fb_read_seq #(
  parameter int WORDS_PER_ROW = gbvga_pkg::WORDS_PER_ROW,
  parameter int FB_AW         = gbvga_pkg::FB_AW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       row,
  input  logic             issue,
  input  logic [7:0]       ram_rdata,
  output logic [FB_AW-1:0] rd_addr,
  output logic             last,
  output logic             lb_we,
  output logic [5:0]       lb_addr,
  output logic [7:0]       lb_data,
  output logic             fetch_done
);
  import gbvga_pkg::*;

  logic [FB_AW-1:0] base;
  logic [5:0]       word;
  rd_slot_t         s1;
  rd_slot_t         s2;

  assign rd_addr = base + FB_AW'(word);
  assign last    = (word == 6'(WORDS_PER_ROW - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base       <= '0;
      word       <= '0;
      s1         <= '0;
      s2         <= '0;
      lb_we      <= 1'b0;
      lb_addr    <= '0;
      lb_data    <= '0;
      fetch_done <= 1'b0;
    end else begin
      // row*40 as row*32 + row*8
      if (start) begin
        base <= (FB_AW'(row) << 5) + (FB_AW'(row) << 3);
        word <= '0;
      end else if (issue && !last) begin
        word <= word + 6'd1;
      end
      // s1: ram_addr on the bus, s2: ram_rdata valid
      s1    <= '{v: issue, idx: word};
      s2    <= s1;
      lb_we <= s2.v;
      if (s2.v) begin
        lb_addr <= s2.idx;
        lb_data <= ram_rdata;
      end
      fetch_done <= s2.v &&
        (s2.idx == 6'(WORDS_PER_ROW - 1));
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares framebuffer RAM between scanout row fetch and capture writes.
// Ports: fetch_* control, lb_* line buffer, wr_* capture handshake, ram_* RAM port.
module fb_arbiter #(
  parameter int ROWS          = gbvga_pkg::GB_H,
  parameter int WORDS_PER_ROW = gbvga_pkg::WORDS_PER_ROW,
  parameter int FB_AW         = gbvga_pkg::FB_AW,
  parameter int WR_PERIOD     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fetch_req,
  input  logic [7:0]       fetch_row,
  output logic             fetch_busy,
  output logic             fetch_done,
  output logic             fetch_err,
  output logic             lb_we,
  output logic [5:0]       lb_addr,
  output logic [7:0]       lb_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  output logic [FB_AW-1:0] ram_addr,
  output logic             ram_we,
  output logic [7:0]       ram_wdata,
  input  logic [7:0]       ram_rdata
);
  import gbvga_pkg::*;

  localparam int SW = (WR_PERIOD > 1) ? $clog2(WR_PERIOD) : 1;

  arb_state_e       state;
  logic [SW-1:0]    slot;
  logic             row_ok;
  logic             start;
  logic             wr_slot;
  logic             wr_hit;
  logic             rd_issue;
  logic             rd_last;
  logic [FB_AW-1:0] rd_addr;

  assign row_ok   = fetch_row < 8'(ROWS);
  assign start    = (state == ARB_IDLE) && fetch_req && row_ok;
  assign wr_slot  = (slot == SW'(WR_PERIOD - 1));
  assign rd_issue = (state == ARB_FETCH) && !(wr_slot && wr_valid);
  // out-of-range writes complete the handshake but never reach the RAM
  assign wr_hit   = wr_valid && wr_ready &&
                    (wr_addr < FB_AW'(ROWS * WORDS_PER_ROW));

  // fetch wins a same-cycle tie in IDLE
  always_comb begin
    wr_ready = 1'b0;
    unique case (1'b1)
      state == ARB_FETCH: wr_ready = wr_slot;
      state == ARB_DRAIN: wr_ready = 1'b1;
      default:            wr_ready = reset_n & ~fetch_req;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      slot       <= '0;
      fetch_busy <= 1'b0;
      fetch_err  <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
    end else begin
      fetch_err <= fetch_req &&
        ((state != ARB_IDLE) || !row_ok);
      ram_we <= wr_hit;
      if (wr_hit) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end else if (rd_issue) begin
        ram_addr <= rd_addr;
      end
      unique case (state)
        ARB_IDLE: begin
          if (start) begin
            state      <= ARB_FETCH;
            slot       <= '0;
            fetch_busy <= 1'b1;
          end
        end
        ARB_FETCH: begin
          slot <= wr_slot ? '0 : slot + 1'b1;
          if (rd_issue && rd_last)
            state <= ARB_DRAIN;
        end
        ARB_DRAIN: begin
          if (fetch_done) begin
            state      <= ARB_IDLE;
            fetch_busy <= 1'b0;
          end
        end
        default: begin
          state      <= ARB_IDLE;
          fetch_busy <= 1'b0;
        end
      endcase
    end
  end

  fb_read_seq #(
    .WORDS_PER_ROW(WORDS_PER_ROW),
    .FB_AW        (FB_AW)
  ) u_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .row       (fetch_row),
    .issue     (rd_issue),
    .ram_rdata (ram_rdata),
    .rd_addr   (rd_addr),
    .last      (rd_last),
    .lb_we     (lb_we),
    .lb_addr   (lb_addr),
    .lb_data   (lb_data),
    .fetch_done(fetch_done)
  );

endmodule
